// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: op codes, result selects, control constants and divider state encoding
package ex_stage_pkg;
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_MFHI_OP = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP = 8'b0001_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [2:0] EXE_RES_NOP        = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
    localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;
endpackage

// File: rtl/ex_stage_div_iter.sv
// div_iter: multi-cycle restoring radix-2 divider on magnitudes with final sign fix-up
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);
    localparam int CW = $clog2(DIV_CYCLES);
    div_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, mag_a, mag_b;
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic [DATA_W:0] trial;
    assign mag_a = signed_i & dividend_i[DATA_W-1] ? -dividend_i : dividend_i;
    assign mag_b = signed_i & divisor_i[DATA_W-1] ? -divisor_i : divisor_i;
    assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        case (state_q)
            DIV_IDLE: if (start_i) begin
                cnt_d  = '0;
                dvs_d  = mag_b;
                rneg_d = signed_i & dividend_i[DATA_W-1];
                // zero divisor: quotient all ones, remainder is the dividend after sign fix
                state_d = divisor_i == '0 ? DIV_DONE : DIV_BUSY;
                rem_d   = divisor_i == '0 ? mag_a : '0;
                quo_d   = divisor_i == '0 ? '1 : mag_a;
                qneg_d  = divisor_i != '0 & signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
            end
            DIV_BUSY: begin
                rem_d   = trial[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
                quo_d   = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(DIV_CYCLES - 1) ? DIV_DONE : DIV_BUSY;
            end
            default: state_d = DIV_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
    assign busy_o      = state_q == DIV_BUSY;
    assign done_o      = state_q == DIV_DONE;
    assign quotient_o  = qneg_q ? -quo_q : quo_q;
    assign remainder_o = rneg_q ? -rem_q : rem_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with combinational ALU/result mux and an iterative divider
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);
    localparam int SHW = $clog2(DATA_W);
    logic in_rst, div_op, div_busy, div_done;
    logic [SHW-1:0] sh;
    logic [DATA_W-1:0] logic_res, shift_res, arith_res, move_res, quo, rem;
    assign in_rst = rst == RstEnable;
    assign sh     = reg1_i[SHW-1:0];
    assign div_op = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
    div_iter #(.DATA_W(DATA_W), .DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_op),
        .signed_i   (aluop_i == EXE_DIV_OP),
        .dividend_i (reg1_i),
        .divisor_i  (reg2_i),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quo),
        .remainder_o(rem)
    );
    assign logic_res = aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                       aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                       aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i :
                       aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) : '0;
    assign shift_res = aluop_i == EXE_SLL_OP ? reg2_i << sh :
                       aluop_i == EXE_SRL_OP ? reg2_i >> sh :
                       aluop_i == EXE_SRA_OP ? DATA_W'($signed(reg2_i) >>> sh) : '0;
    assign arith_res = aluop_i == EXE_ADDU_OP ? reg1_i + reg2_i :
                       aluop_i == EXE_SUBU_OP ? reg1_i - reg2_i :
                       aluop_i == EXE_SLT_OP  ? DATA_W'($signed(reg1_i) < $signed(reg2_i)) :
                       aluop_i == EXE_SLTU_OP ? DATA_W'(reg1_i < reg2_i) : '0;
    assign move_res  = aluop_i == EXE_MFHI_OP ? hi_i :
                       aluop_i == EXE_MFLO_OP ? lo_i : '0;
    assign wdata_o = in_rst                           ? '0 :
                     alusel_i == EXE_RES_LOGIC        ? logic_res :
                     alusel_i == EXE_RES_SHIFT        ? shift_res :
                     alusel_i == EXE_RES_ARITHMETIC   ? arith_res :
                     alusel_i == EXE_RES_MOVE         ? move_res : '0;
    assign wd_o   = in_rst ? NOPRegAddr : wd_i;
    assign wreg_o = in_rst | div_op ? WriteDisable : wreg_i;
    // DONE is excluded so the held division retires instead of restarting
    assign stallreq_o = ~in_rst & (div_busy | (div_op & ~div_done));
    always_comb begin
        whilo_o = WriteDisable;
        hi_o    = '0;
        lo_o    = '0;
        if (!in_rst) begin
            if (div_done) begin
                whilo_o = WriteEnable;
                hi_o    = rem;
                lo_o    = quo;
            end else if (aluop_i == EXE_MTHI_OP || aluop_i == EXE_MTLO_OP) begin
                whilo_o = WriteEnable;
                hi_o    = aluop_i == EXE_MTHI_OP ? reg1_i : hi_i;
                lo_o    = aluop_i == EXE_MTLO_OP ? reg1_i : lo_i;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: random and directed stimulus checked against a transaction-level model of ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] aluop_i;
    logic [2:0] alusel_i;
    logic [31:0] reg1_i, reg2_i, hi_i, lo_i;
    logic [4:0] wd_i;
    logic wreg_i;
    logic [4:0] wd_o;
    logic wreg_o, whilo_o, stallreq_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    int vectors = 0, errs = 0;
    int k = 0;
    logic [7:0] op_tab [18];
    logic [2:0] sel_tab [18];
    logic [31:0] edge_v [6];
    always #5 clk = ~clk;
    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .hi_i(hi_i), .lo_i(lo_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );
    function automatic logic is_div(input logic [7:0] op);
        return op == EXE_DIV_OP || op == EXE_DIVU_OP;
    endfunction
    // a division occupies EX for 34 cycles, or 2 when the divisor is zero
    function automatic int div_len(input logic [31:0] b);
        return b == 0 ? 2 : 34;
    endfunction
    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sa = sgn ? longint'(int'(a)) : longint'(a);
        sb = sgn ? longint'(int'(b)) : longint'(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction
    function automatic logic [31:0] alu_ref(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] h, input logic [31:0] l);
        int sh;
        sh = int'(a[4:0]);
        case (sel)
            EXE_RES_LOGIC: case (op)
                EXE_OR_OP:  return a | b;
                EXE_AND_OP: return a & b;
                EXE_XOR_OP: return a ^ b;
                EXE_NOR_OP: return ~(a | b);
                default:    return 0;
            endcase
            EXE_RES_SHIFT: case (op)
                EXE_SLL_OP: return b << sh;
                EXE_SRL_OP: return b >> sh;
                EXE_SRA_OP: return 32'(int'(b) >>> sh);
                default:    return 0;
            endcase
            EXE_RES_ARITHMETIC: case (op)
                EXE_ADDU_OP: return a + b;
                EXE_SUBU_OP: return a - b;
                EXE_SLT_OP:  return (int'(a) < int'(b)) ? 1 : 0;
                EXE_SLTU_OP: return (a < b) ? 1 : 0;
                default:     return 0;
            endcase
            EXE_RES_MOVE: return op == EXE_MFHI_OP ? h : op == EXE_MFLO_OP ? l : 0;
            default: return 0;
        endcase
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    always @(posedge clk) begin
        if (rst) k = 0;
        else if (is_div(aluop_i)) k = (k == div_len(reg2_i) - 1) ? 0 : k + 1;
        else k = 0;
    end
    logic [31:0] e_hi, e_lo, e_wdata;
    logic [63:0] e_div;
    logic e_whilo, e_stall;
    always @(negedge clk) begin
        e_whilo = 1'b0;
        e_stall = 1'b0;
        e_hi = 0;
        e_lo = 0;
        if (!rst) begin
            if (is_div(aluop_i)) begin
                e_stall = k < div_len(reg2_i) - 1;
                if (k == div_len(reg2_i) - 1) begin
                    e_div = div_ref(aluop_i == EXE_DIV_OP, reg1_i, reg2_i);
                    e_whilo = 1'b1;
                    e_hi = e_div[63:32];
                    e_lo = e_div[31:0];
                end
            end else if (aluop_i == EXE_MTHI_OP) begin
                e_whilo = 1'b1;
                e_hi = reg1_i;
                e_lo = lo_i;
            end else if (aluop_i == EXE_MTLO_OP) begin
                e_whilo = 1'b1;
                e_hi = hi_i;
                e_lo = reg1_i;
            end
        end
        e_wdata = rst ? 0 : alu_ref(aluop_i, alusel_i, reg1_i, reg2_i, hi_i, lo_i);
        chk("wd", 32'(wd_o), rst ? 0 : 32'(wd_i));
        chk("wreg", 32'(wreg_o), (rst || is_div(aluop_i)) ? 0 : 32'(wreg_i));
        chk("wdata", wdata_o, e_wdata);
        chk("stall", 32'(stallreq_o), 32'(e_stall));
        chk("whilo", 32'(whilo_o), 32'(e_whilo));
        chk("hi", hi_o, e_hi);
        chk("lo", lo_o, e_lo);
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        aluop_i = op;
        alusel_i = sel;
        reg1_i = a;
        reg2_i = b;
        wd_i = 5'($urandom);
        wreg_i = 1'($urandom);
        hi_i = $urandom;
        lo_i = $urandom;
    endtask
    task automatic div_run(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cyc_n, output int st_n, output logic [31:0] h,
                           output logic [31:0] l, output logic wr);
        drive(op, EXE_RES_NOP, a, b);
        wreg_i = 1'b1;
        cyc_n = 0;
        st_n = 0;
        h = 0;
        l = 0;
        wr = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc_n++;
            if (stallreq_o) st_n++;
            if (whilo_o) begin
                h = hi_o;
                l = lo_o;
                wr = wreg_o;
                break;
            end
            cyc();
        end
        cyc();
    endtask
    function automatic logic [31:0] rnd_word();
        return $urandom_range(0, 3) == 0 ? edge_v[$urandom_range(0, 5)] : $urandom;
    endfunction
    initial begin
        int cn, sn;
        logic [31:0] h, l, a, b;
        logic wr;
        op_tab  = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_SLL_OP, EXE_SRL_OP,
                    EXE_SRA_OP, EXE_ADDU_OP, EXE_SUBU_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_MFHI_OP,
                    EXE_MFLO_OP, EXE_MTHI_OP, EXE_MTLO_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_NOP_OP};
        sel_tab = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                    EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC,
                    EXE_RES_ARITHMETIC, EXE_RES_ARITHMETIC, EXE_RES_MOVE, EXE_RES_MOVE,
                    EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP, EXE_RES_NOP};
        edge_v  = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h1, 32'h2);
        @(negedge clk);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_stall", 32'(stallreq_o), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
        drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h2);
        wreg_i = 1'b1;
        @(negedge clk);
        chk("addu_wdata", wdata_o, 32'h1);
        chk("addu_wreg", 32'(wreg_o), 32'h1);
        chk("addu_stall", 32'(stallreq_o), 32'h0);
        cyc();
        drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'h4, 32'h8000_0000);
        @(negedge clk);
        chk("sra", wdata_o, 32'hF800_0000);
        cyc();
        drive(EXE_SLT_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        chk("slt", wdata_o, 32'h1);
        cyc();
        drive(EXE_SLTU_OP, EXE_RES_ARITHMETIC, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk);
        chk("sltu", wdata_o, 32'h0);
        cyc();
        div_run(EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, cn, sn, h, l, wr);
        chk("div_cycles", cn, 34);
        chk("div_stall_cycles", sn, 33);
        chk("div_lo", l, 32'hFFFF_FFFD);
        chk("div_hi", h, 32'hFFFF_FFFF);
        chk("div_wreg", 32'(wr), 32'h0);
        drive(EXE_ADDU_OP, EXE_RES_ARITHMETIC, 32'h5, 32'h6);
        @(negedge clk);
        chk("after_div_wdata", wdata_o, 32'hB);
        chk("after_div_stall", 32'(stallreq_o), 32'h0);
        cyc();
        div_run(EXE_DIVU_OP, 32'h8000_0000, 32'h3, cn, sn, h, l, wr);
        chk("divu_cycles", cn, 34);
        chk("divu_lo", l, 32'h2AAA_AAAA);
        chk("divu_hi", h, 32'h2);
        div_run(EXE_DIV_OP, 32'h1234_5678, 32'h0, cn, sn, h, l, wr);
        chk("dz_cycles", cn, 2);
        chk("dz_stall_cycles", sn, 1);
        chk("dz_lo", l, 32'hFFFF_FFFF);
        chk("dz_hi", h, 32'h1234_5678);
        drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7);
        repeat (10) cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_stall", 32'(stallreq_o), 32'h0);
        chk("mid_rst_whilo", 32'(whilo_o), 32'h0);
        chk("mid_rst_hi", hi_o, 32'h0);
        chk("mid_rst_wd", 32'(wd_o), 32'h0);
        cyc();
        rst = 1'b0;
        drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hA5, 32'h0);
        hi_i = 32'hCAFE_0001;
        @(negedge clk);
        chk("mtlo_whilo", 32'(whilo_o), 32'h1);
        chk("mtlo_lo", lo_o, 32'hA5);
        chk("mtlo_hi", hi_o, 32'hCAFE_0001);
        cyc();
        for (int n = 0; n < 300; n++) begin
            int t;
            logic [2:0] sel;
            t = $urandom_range(0, 17);
            sel = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) == 0 ? EXE_RES_NOP : 3'($urandom_range(5, 7))) : sel_tab[t];
            a = rnd_word();
            b = (is_div(op_tab[t]) && $urandom_range(0, 5) == 0) ? 32'h0 : rnd_word();
            drive(op_tab[t], sel, a, b);
            if (is_div(op_tab[t])) repeat (div_len(b)) cyc();
            else cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
